// File: rtl/grasspopper_pkg.sv
// Shared Kuznyechik constants for the grasspopper encoder/decoder pair.
// Round keys, S-box tables, linear-layer coefficients and FSM encoding.
package grasspopper_pkg;

  typedef logic [127:0] block_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LINV = 2'd1;
  localparam logic [1:0] ST_SINV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] PI [256] = '{
    8'hfc, 8'hee, 8'hdd, 8'h11, 8'hcf, 8'h6e, 8'h31, 8'h16,
    8'hfb, 8'hc4, 8'hfa, 8'hda, 8'h23, 8'hc5, 8'h04, 8'h4d,
    8'he9, 8'h77, 8'hf0, 8'hdb, 8'h93, 8'h2e, 8'h99, 8'hba,
    8'h17, 8'h36, 8'hf1, 8'hbb, 8'h14, 8'hcd, 8'h5f, 8'hc1,
    8'hf9, 8'h18, 8'h65, 8'h5a, 8'he2, 8'h5c, 8'hef, 8'h21,
    8'h81, 8'h1c, 8'h3c, 8'h42, 8'h8b, 8'h01, 8'h8e, 8'h4f,
    8'h05, 8'h84, 8'h02, 8'hae, 8'he3, 8'h6a, 8'h8f, 8'ha0,
    8'h06, 8'h0b, 8'hed, 8'h98, 8'h7f, 8'hd4, 8'hd3, 8'h1f,
    8'heb, 8'h34, 8'h2c, 8'h51, 8'hea, 8'hc8, 8'h48, 8'hab,
    8'hf2, 8'h2a, 8'h68, 8'ha2, 8'hfd, 8'h3a, 8'hce, 8'hcc,
    8'hb5, 8'h70, 8'h0e, 8'h56, 8'h08, 8'h0c, 8'h76, 8'h12,
    8'hbf, 8'h72, 8'h13, 8'h47, 8'h9c, 8'hb7, 8'h5d, 8'h87,
    8'h15, 8'ha1, 8'h96, 8'h29, 8'h10, 8'h7b, 8'h9a, 8'hc7,
    8'hf3, 8'h91, 8'h78, 8'h6f, 8'h9d, 8'h9e, 8'hb2, 8'hb1,
    8'h32, 8'h75, 8'h19, 8'h3d, 8'hff, 8'h35, 8'h8a, 8'h7e,
    8'h6d, 8'h54, 8'hc6, 8'h80, 8'hc3, 8'hbd, 8'h0d, 8'h57,
    8'hdf, 8'hf5, 8'h24, 8'ha9, 8'h3e, 8'ha8, 8'h43, 8'hc9,
    8'hd7, 8'h79, 8'hd6, 8'hf6, 8'h7c, 8'h22, 8'hb9, 8'h03,
    8'he0, 8'h0f, 8'hec, 8'hde, 8'h7a, 8'h94, 8'hb0, 8'hbc,
    8'hdc, 8'he8, 8'h28, 8'h50, 8'h4e, 8'h33, 8'h0a, 8'h4a,
    8'ha7, 8'h97, 8'h60, 8'h73, 8'h1e, 8'h00, 8'h62, 8'h44,
    8'h1a, 8'hb8, 8'h38, 8'h82, 8'h64, 8'h9f, 8'h26, 8'h41,
    8'had, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5e, 8'h55, 8'h2f,
    8'h8c, 8'ha3, 8'ha5, 8'h7d, 8'h69, 8'hd5, 8'h95, 8'h3b,
    8'h07, 8'h58, 8'hb3, 8'h40, 8'h86, 8'hac, 8'h1d, 8'hf7,
    8'h30, 8'h37, 8'h6b, 8'he4, 8'h88, 8'hd9, 8'he7, 8'h89,
    8'he1, 8'h1b, 8'h83, 8'h49, 8'h4c, 8'h3f, 8'hf8, 8'hfe,
    8'h8d, 8'h53, 8'haa, 8'h90, 8'hca, 8'hd8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'ha4, 8'h2d, 8'h2b, 8'h09, 8'h5b,
    8'hcb, 8'h9b, 8'h25, 8'hd0, 8'hbe, 8'he5, 8'h6c, 8'h52,
    8'h59, 8'ha6, 8'h74, 8'hd2, 8'he6, 8'hf4, 8'hb4, 8'hc0,
    8'hd1, 8'h66, 8'haf, 8'hc2, 8'h39, 8'h4b, 8'h63, 8'hb6
  };

  // coefficient i multiplies byte b_i of the l() input
  localparam logic [7:0] L_COEF [16] = '{
    8'h01, 8'h94, 8'h20, 8'h85, 8'h10, 8'hc2, 8'hc0, 8'h01,
    8'hfb, 8'h01, 8'hc0, 8'hc2, 8'h10, 8'h85, 8'h20, 8'h94
  };

  function automatic logic [7:0] gf_mul(
    logic [7:0] a,
    logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hc3 : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [255:0][7:0] build_pi_inv();
    logic [255:0][7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      r[PI[i]] = 8'(i);
    return r;
  endfunction

  localparam logic [255:0][7:0] PI_INV = build_pi_inv();

  function automatic block_t round_key(logic [3:0] r);
    block_t k;
    k = '0;
    case (r)
      4'd1:  k = 128'h8899aabbccddeeff0011223344556677;
      4'd2:  k = 128'hfedcba98765432100123456789abcdef;
      4'd3:  k = 128'hdb31485315694343228d6aef8cc78c44;
      4'd4:  k = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
      4'd5:  k = 128'h57646468c44a5e28d3e59246f429f1ac;
      4'd6:  k = 128'hbd079435165c6432b532e82834da581b;
      4'd7:  k = 128'h51e640757e8745de705727265a0098b1;
      4'd8:  k = 128'h5a7925017b9fdd3ed72a91a22286f984;
      4'd9:  k = 128'hbb44e25378c73123a5f32f73cdb6e517;
      4'd10: k = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/grasspopper_lin_step.sv
// One inverse linear step R^-1: shift left a byte, append l() of the
// byte-rotated vector.
module grasspopper_lin_step
  import grasspopper_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);

  logic [127:0] rot;
  logic [7:0]   acc;

  assign rot = {din[119:0], din[127:120]};

  always_comb begin
    acc = '0;
    for (int i = 0; i < 16; i++)
      acc = acc ^ gf_mul(rot[8*i +: 8], L_COEF[i]);
  end

  assign dout = {din[119:0], acc};

endmodule

// File: rtl/grasspopper_decoder.sv
// Iterative Kuznyechik decryption: 16 R^-1 steps then S^-1 plus key,
// nine rounds, one block in flight at a time.
module grasspopper_decoder
  import grasspopper_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_i,
  input  logic         valid_i,
  output logic [127:0] data_o,
  output logic         valid_o,
  output logic         busy
);

  logic [1:0] state;
  block_t     s;
  block_t     s_lin;
  block_t     s_sub;
  logic [3:0] rnd;
  logic [3:0] cnt;

  grasspopper_lin_step u_lin (
    .din  (s),
    .dout (s_lin)
  );

  always_comb begin
    s_sub = round_key(rnd);
    for (int i = 0; i < 16; i++)
      s_sub[8*i +: 8] = s_sub[8*i +: 8] ^ PI_INV[s[8*i +: 8]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      s       <= '0;
      rnd     <= '0;
      cnt     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (valid_i) begin
            s     <= data_i ^ round_key(4'd10);
            rnd   <= 4'd9;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_LINV;
          end
        end
        ST_LINV: begin
          s   <= s_lin;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= ST_SINV;
        end
        ST_SINV: begin
          s   <= s_sub;
          cnt <= '0;
          if (rnd == 4'd1) begin
            state <= ST_DONE;
          end else begin
            rnd   <= rnd - 4'd1;
            state <= ST_LINV;
          end
        end
        ST_DONE: begin
          data_o  <= s;
          valid_o <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
